jtframe_hsize_ctrl: RTL and testbench
=====================================

Name: jtframe_hsize_ctrl

Overview:
- Sequences configuration changes for the horizontal scaler (scale, offset, enable) so that new settings never land mid-frame.
- Menu or OSD requests are debounced over whole frames, the picture is muted for one frame, then the new values are committed on a VS rising edge.
- A line-presence watchdog forces the scaler into bypass when HS disappears.
- Sits between the frame's status/menu decoder and the scaler's scale/offset/enable inputs, in the pixel clock domain.

Parameters:
- STABLE_FRAMES, 2: number of VS rising edges a request must stay unchanged before it is committed; range 1–15.
- HS_TIMEOUT, 1023: pxl_cen ticks without an HS rising edge before video is declared lost; 10-bit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pxl_cen  in  1  pixel clock enable; all sampling and state updates are qualified by it
- HS  in  1  horizontal sync, active high
- VS  in  1  vertical sync, active high
- req_scale  in  4  requested scale, signed, −8..7
- req_offset  in  5  requested offset, signed
- req_enable  in  1  requested scaler enable
- scale  out  4  committed scale to scaler
- offset  out  5  committed offset to scaler
- enable  out  1  committed enable, ANDed with video_ok
- mute  out  1  forces the colour output to black while high
- busy  out  1  high in any state other than IDLE
- video_ok  out  1  HS present

Behaviour:
- Reset (async, rst_n low): scale=0, offset=0, enable=0, mute=0, busy=0, video_ok=0, state=IDLE, stable_cnt=0, candidate={0,0,0}, edge registers cleared.
- Edge detect: HSl and VSl are registered on pxl_cen. vs_edge = pxl_cen & VS & ~VSl; hs_edge likewise.
- Change detect: while pxl_cen, if {req_*} != candidate:
  - candidate <= req
  - stable_cnt <= 0
  - state <= SETTLE
  - This applies from any state. If the state was MUTE or COMMIT, mute stays high and the sequence restarts from SETTLE.
- IDLE:
  - busy=0.
  - Leaves only via change detect, and only if candidate != committed values; otherwise stays IDLE.
- SETTLE:
  - On each vs_edge, stable_cnt++.
  - When the increment makes stable_cnt == STABLE_FRAMES: mute <= 1 in the same cycle, state <= MUTE.
- MUTE:
  - On the next vs_edge, commit the candidate (see Optional Feature), state <= COMMIT.
  - Outputs change exactly on that pxl_cen cycle.
- COMMIT:
  - On the next vs_edge, either mute <= 0 and state <= IDLE, or (ramp only) stay in MUTE-commit stepping.
  - Mute therefore spans at least one full frame before and one full frame after the commit.
- Simultaneous events:
  - A request change on the same cycle as a vs_edge wins; stable_cnt resets to 0, not 1.
  - A vs_edge coinciding with a watchdog timeout is processed normally; the watchdog only gates enable.
- Watchdog:
  - hs_cnt (10 bits) clears on hs_edge and otherwise increments per pxl_cen, saturating at HS_TIMEOUT.
  - Reaching HS_TIMEOUT sets video_ok <= 0.
  - The first hs_edge sets video_ok <= 1.
  - enable output = enable_reg & video_ok, combinational.
  - The state machine keeps running while video is lost. No vs_edge arrives then, so it simply waits.
- Latency: minimum request-to-commit is STABLE_FRAMES+1 VS edges.

Optional Feature:
- Macro: JTFRAME_HSIZE_RAMP_EN.
- Defined:
  - In the MUTE→COMMIT step, offset and enable jump to the candidate.
  - scale moves one step (signed ±1) toward the candidate per vs_edge, staying in COMMIT while scale != candidate.
  - mute drops one vs_edge after scale reaches the candidate.
  - Ramping is monotonic; no wrap from 7 to −8.
- Undefined: scale, offset and enable all jump to the candidate on a single vs_edge.

Decomposition:
- Shared package jtframe_hsize_pkg holds:
  - state enum IDLE/SETTLE/MUTE/COMMIT (2 bits)
  - SCALE_W=4, OFFSET_W=5
  - a signed-step function for the ramp
- One natural sub-module: jtframe_hsize_wdog (HS watchdog counter producing video_ok).

Test Plan:
- Reset, then HS every 384 pxl_cen and VS every 262 lines → video_ok=1 after the first HS; enable=0, scale=0, busy=0.
- req_scale=3, req_enable=1, STABLE_FRAMES=2:
  - mute rises on the 2nd VS edge
  - scale=3 and enable=1 on the 3rd
  - mute falls on the 4th
- Request toggles 3→5 between the 1st and 2nd VS edges → stable_cnt restarts; scale=5 commits on the 3rd VS edge after the last change; the value 3 never appears.
- Stop HS for 1023 pxl_cen → video_ok=0 and enable=0 while enable_reg=1; the next HS restores enable=1.
- With RAMP_EN, scale 0→−3 → scale reads −1, −2, −3 on successive VS edges, then mute falls one edge later.
- Assert rst_n low during MUTE → all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/jtframe_hsize_pkg.sv
// Shared types and helpers for the horizontal scaler configuration sequencer.
// The optional scale ramp (JTFRAME_HSIZE_RAMP_EN) uses scale_step from here.
package jtframe_hsize_pkg;

    localparam int unsigned SCALE_W  = 4;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned STABLE_W = 4;
    localparam int unsigned HS_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        MUTE   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [SCALE_W-1:0]  scale;
        logic [OFFSET_W-1:0] offset;
        logic                enable;
    } hsize_cfg_t;

    // One signed step of cur toward tgt; never wraps because it stops at tgt.
    function automatic logic [SCALE_W-1:0] scale_step(
        input logic [SCALE_W-1:0] cur,
        input logic [SCALE_W-1:0] tgt
    );
        logic [SCALE_W-1:0] res;
        res = cur;
        if ($signed(cur) < $signed(tgt)) begin
            res = cur + SCALE_W'(1);
        end else if ($signed(cur) > $signed(tgt)) begin
            res = cur - SCALE_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_hsize_wdog.sv
// HS presence watchdog: video_ok drops after HS_TIMEOUT pixel ticks without
// an HS rising edge and returns on the next one.
module jtframe_hsize_wdog
    import jtframe_hsize_pkg::*;
#(
    parameter int unsigned HS_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pxl_cen,
    input  logic hs_edge,
    output logic video_ok
);

    localparam logic [HS_CNT_W-1:0] TIMEOUT = HS_CNT_W'(HS_TIMEOUT);

    logic [HS_CNT_W-1:0] hs_cnt;

    // Saturating tick counter, cleared by every HS rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_cnt   <= '0;
            video_ok <= 1'b0;
        end else if (pxl_cen) begin
            if (hs_edge) begin
                hs_cnt   <= '0;
                video_ok <= 1'b1;
            end else if (hs_cnt != TIMEOUT) begin
                hs_cnt <= hs_cnt + HS_CNT_W'(1);
                if (hs_cnt + HS_CNT_W'(1) == TIMEOUT) begin
                    video_ok <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_hsize_ctrl.sv
// Frame-synchronous commit of scaler scale/offset/enable with mute and HS watchdog.
// Define JTFRAME_HSIZE_RAMP_EN to ramp scale one step per VS edge instead of jumping.
module jtframe_hsize_ctrl
    import jtframe_hsize_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned HS_TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pxl_cen,
    input  logic                HS,
    input  logic                VS,
    input  logic [SCALE_W-1:0]  req_scale,
    input  logic [OFFSET_W-1:0] req_offset,
    input  logic                req_enable,
    output logic [SCALE_W-1:0]  scale,
    output logic [OFFSET_W-1:0] offset,
    output logic                enable,
    output logic                mute,
    output logic                busy,
    output logic                video_ok
);

    localparam logic [STABLE_W-1:0] STABLE_LIM = STABLE_W'(STABLE_FRAMES);

    state_t              state_q, state_nx;
    logic [STABLE_W-1:0] cnt_q, cnt_nx;
    hsize_cfg_t          cand_q, cand_nx;
    hsize_cfg_t          cur_q, cur_nx;
    hsize_cfg_t          req_w;
    logic                mute_q, mute_nx;
    logic                busy_q, busy_nx;
    logic                hsl_q, vsl_q;
    logic                hs_edge, vs_edge;

    assign req_w   = {req_scale, req_offset, req_enable};
    assign hs_edge = pxl_cen & HS & ~hsl_q;
    assign vs_edge = pxl_cen & VS & ~vsl_q;

    jtframe_hsize_wdog #(
        .HS_TIMEOUT (HS_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .hs_edge  (hs_edge),
        .video_ok (video_ok)
    );

    // Sync edge registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsl_q <= 1'b0;
            vsl_q <= 1'b0;
        end else if (pxl_cen) begin
            hsl_q <= HS;
            vsl_q <= VS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            cur_q   <= '0;
            mute_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            cand_q  <= cand_nx;
            cur_q   <= cur_nx;
            mute_q  <= mute_nx;
            busy_q  <= busy_nx;
        end
    end

    // A request change always beats a coincident VS edge and restarts settling
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        cand_nx  = cand_q;
        cur_nx   = cur_q;
        mute_nx  = mute_q;
        if (pxl_cen) begin
            if (req_w != cand_q) begin
                cand_nx = req_w;
                if (state_q != IDLE || req_w != cur_q) begin
                    cnt_nx   = '0;
                    state_nx = SETTLE;
                end
            end else if (vs_edge) begin
                case (state_q)
                    SETTLE: begin
                        cnt_nx = cnt_q + STABLE_W'(1);
                        if (cnt_nx == STABLE_LIM) begin
                            mute_nx  = 1'b1;
                            state_nx = MUTE;
                        end
                    end
                    MUTE: begin
                        cur_nx = cand_q;
`ifdef JTFRAME_HSIZE_RAMP_EN
                        cur_nx.scale = scale_step(cur_q.scale, cand_q.scale);
`endif
                        state_nx = COMMIT;
                    end
                    COMMIT: begin
`ifdef JTFRAME_HSIZE_RAMP_EN
                        if (cur_q.scale != cand_q.scale) begin
                            cur_nx.scale = scale_step(cur_q.scale, cand_q.scale);
                        end else begin
                            mute_nx  = 1'b0;
                            state_nx = IDLE;
                        end
`else
                        mute_nx  = 1'b0;
                        state_nx = IDLE;
`endif
                    end
                    default: ;
                endcase
            end
        end
        busy_nx = (state_nx != IDLE);
    end

    assign scale  = cur_q.scale;
    assign offset = cur_q.offset;
    assign enable = cur_q.enable & video_ok;
    assign mute   = mute_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_jtframe_hsize_ctrl.sv
// Self-checking bench for jtframe_hsize_ctrl: frame-level reference model,
// directed scenarios with literal expectations, then randomized requests.
module tb_jtframe_hsize_ctrl;

    localparam int SF     = 2;
    localparam int HS_TO  = 1023;
    localparam int HPER   = 16;
    localparam int VLINES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen = 1'b0;
    logic       HS = 1'b0;
    logic       VS = 1'b0;
    logic [3:0] req_scale = '0;
    logic [4:0] req_offset = '0;
    logic       req_enable = 1'b0;
    logic [3:0] scale;
    logic [4:0] offset;
    logic       enable, mute, busy, video_ok;

    int checks = 0;
    int failures = 0;

    jtframe_hsize_ctrl #(
        .STABLE_FRAMES (SF),
        .HS_TIMEOUT    (HS_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_cen    (pxl_cen),
        .HS         (HS),
        .VS         (VS),
        .req_scale  (req_scale),
        .req_offset (req_offset),
        .req_enable (req_enable),
        .scale      (scale),
        .offset     (offset),
        .enable     (enable),
        .mute       (mute),
        .busy       (busy),
        .video_ok   (video_ok)
    );

    always #5 clk = ~clk;

    // Reference model state: k counts VS edges since the last effective request change
    int m_cand_s = 0, m_cand_o = 0, m_com_s = 0, m_com_o = 0;
    bit m_cand_e = 0, m_com_e = 0;
    bit m_pending = 0, m_mute = 0, m_vok = 0, m_vsl = 0, m_hsl = 0;
    int m_k = 0, m_since = 0;
    int vs_edges = 0, ticks = 0;
    bit sync_on = 1;
    bit t_vs, t_hs, t_re;
    int t_rs, t_ro;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting @%0t", name, $time);
    endtask

    // Sync generator: HS pulse of 2 ticks per HPER-tick line, VS high on line 0
    initial begin
        int hc, vc;
        hc = 0;
        vc = 0;
        forever begin
            @(posedge clk);
            #2;
            if (pxl_cen) begin
                hc++;
                if (hc == HPER) begin
                    hc = 0;
                    vc = (vc + 1) % VLINES;
                end
            end
            HS = sync_on && (hc < 2);
            VS = sync_on && (vc == 0);
            pxl_cen = ($urandom_range(3) != 0);
        end
    end

    // Behavioural model
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cand_s = 0; m_cand_o = 0; m_cand_e = 0;
            m_com_s = 0;  m_com_o = 0;  m_com_e = 0;
            m_pending = 0; m_mute = 0; m_k = 0;
            m_vok = 0; m_since = 0; m_vsl = 0; m_hsl = 0;
        end else if (pxl_cen) begin
            ticks++;
            t_vs = VS && !m_vsl;
            t_hs = HS && !m_hsl;
            m_vsl = VS;
            m_hsl = HS;
            if (t_hs) begin
                m_since = 0;
                m_vok = 1;
            end else begin
                if (m_since < HS_TO) m_since++;
                if (m_since >= HS_TO) m_vok = 0;
            end
            if (t_vs) vs_edges++;
            t_rs = int'($signed(req_scale));
            t_ro = int'(req_offset);
            t_re = req_enable;
            if (t_rs != m_cand_s || t_ro != m_cand_o || t_re != m_cand_e) begin
                m_cand_s = t_rs; m_cand_o = t_ro; m_cand_e = t_re;
                if (m_pending || t_rs != m_com_s || t_ro != m_com_o || t_re != m_com_e) begin
                    m_pending = 1;
                    m_k = 0;
                end
            end else if (t_vs && m_pending) begin
                m_k++;
                if (m_k == SF) begin
                    m_mute = 1;
                end else if (m_k == SF + 1) begin
                    m_com_o = m_cand_o;
                    m_com_e = m_cand_e;
`ifdef JTFRAME_HSIZE_RAMP_EN
                    if (m_com_s < m_cand_s) m_com_s++;
                    else if (m_com_s > m_cand_s) m_com_s--;
`else
                    m_com_s = m_cand_s;
`endif
                end else if (m_k > SF + 1) begin
                    if (m_com_s < m_cand_s) m_com_s++;
                    else if (m_com_s > m_cand_s) m_com_s--;
                    else begin
                        m_mute = 0;
                        m_pending = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("scale", int'($signed(scale)), m_com_s);
        check("offset", int'(offset), m_com_o);
        check("enable", int'(enable), int'(m_com_e && m_vok));
        check("mute", int'(mute), int'(m_mute));
        check("busy", int'(busy), int'(m_pending));
        check("video_ok", int'(video_ok), int'(m_vok));
    end

    task automatic wait_vs(input int n);
        int tgt, cyc;
        tgt = vs_edges + n;
        cyc = 0;
        while (vs_edges < tgt && cyc < 1000 * n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (vs_edges < tgt) timeout("wait_vs");
    endtask

    task automatic step_edge(input string tag, input int es, input int em, input int eb);
        wait_vs(1);
        check({tag, "_scale"}, int'($signed(scale)), es);
        check({tag, "_mute"}, int'(mute), em);
        check({tag, "_busy"}, int'(busy), eb);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((m_pending || m_mute) && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (m_pending || m_mute) timeout("wait_idle");
    endtask

    task automatic wait_vok();
        int cyc;
        cyc = 0;
        while (!m_vok && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!m_vok) timeout("wait_vok");
    endtask

    task automatic set_req(input logic [3:0] s, input logic [4:0] o, input logic e);
        req_scale = s;
        req_offset = o;
        req_enable = e;
    endtask

    initial begin
        int cyc, tgt;
        bit hit;
        rst_n = 1'b0;
        #12;
        check("rst_scale", int'(scale), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_video_ok", int'(video_ok), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Sync present, nothing requested yet
        wait_vok();
        #1;
        check("t0_video_ok", int'(video_ok), 1);
        check("t0_enable", int'(enable), 0);
        check("t0_scale", int'(scale), 0);
        check("t0_busy", int'(busy), 0);

        // 0 -> {3, 0, 1}
        wait_vs(1);
        set_req(4'd3, 5'd0, 1'b1);
        step_edge("t1e1", 0, 0, 1);
        step_edge("t1e2", 0, 1, 1);
`ifdef JTFRAME_HSIZE_RAMP_EN
        step_edge("t1e3", 1, 1, 1);
        step_edge("t1e4", 2, 1, 1);
        step_edge("t1e5", 3, 1, 1);
        step_edge("t1e6", 3, 0, 0);
`else
        step_edge("t1e3", 3, 1, 1);
        check("t1e3_enable", int'(enable), 1);
        step_edge("t1e4", 3, 0, 0);
`endif

        // Request change landing on the same tick as a VS edge restarts the count at 0
        wait_vs(1);
        set_req(4'hE, 5'd7, 1'b1);
        step_edge("t2e1", 3, 0, 1);
        cyc = 0;
        hit = 0;
        while (!hit && cyc < 2000) begin
            @(posedge clk);
            #3;
            if (VS && !m_vsl && pxl_cen) begin
                req_scale = 4'd6;
                hit = 1;
            end
            cyc++;
        end
        if (!hit) timeout("coincident_edge");
        @(posedge clk);
        #1;
        check("t2c_mute", int'(mute), 0);
        check("t2c_busy", int'(busy), 1);
        step_edge("t2k1", 3, 0, 1);
        step_edge("t2k2", 3, 1, 1);
`ifdef JTFRAME_HSIZE_RAMP_EN
        step_edge("t2k3", 4, 1, 1);
`else
        step_edge("t2k3", 6, 1, 1);
        check("t2k3_offset", int'(offset), 7);
`endif
        wait_idle();

        // Asynchronous reset while muted
        wait_vs(1);
        set_req(4'd1, 5'd3, 1'b1);
        cyc = 0;
        while (!(m_pending && m_k == SF) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!(m_pending && m_k == SF)) timeout("wait_mute");
        #3 rst_n = 1'b0;
        #1;
        check("arst_scale", int'(scale), 0);
        check("arst_offset", int'(offset), 0);
        check("arst_enable", int'(enable), 0);
        check("arst_mute", int'(mute), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_video_ok", int'(video_ok), 0);
        set_req(4'd0, 5'd0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_vok();

        // 0 -> -3
        wait_vs(1);
        set_req(4'hD, 5'd2, 1'b1);
        step_edge("t3e1", 0, 0, 1);
        step_edge("t3e2", 0, 1, 1);
`ifdef JTFRAME_HSIZE_RAMP_EN
        step_edge("t3e3", -1, 1, 1);
        step_edge("t3e4", -2, 1, 1);
        step_edge("t3e5", -3, 1, 1);
        step_edge("t3e6", -3, 0, 0);
`else
        step_edge("t3e3", -3, 1, 1);
        step_edge("t3e4", -3, 0, 0);
`endif

        // Toggle 3 -> 5 before it settles; 3 must never be committed
        wait_vs(1);
        req_scale = 4'd3;
        step_edge("t4e1", -3, 0, 1);
        req_scale = 4'd5;
        step_edge("t4k1", -3, 0, 1);
        step_edge("t4k2", -3, 1, 1);
`ifdef JTFRAME_HSIZE_RAMP_EN
        step_edge("t4k3", -2, 1, 1);
`else
        step_edge("t4k3", 5, 1, 1);
        step_edge("t4k4", 5, 0, 0);
`endif
        wait_idle();

        // HS loss gates enable; next HS restores it
        #1;
        check("wd_pre_enable", int'(enable), 1);
        sync_on = 0;
        tgt = ticks + HS_TO + 20;
        cyc = 0;
        while (ticks < tgt && cyc < 4 * (HS_TO + 100)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (ticks < tgt) timeout("wd_ticks");
        check("wd_video_ok", int'(video_ok), 0);
        check("wd_enable", int'(enable), 0);
        sync_on = 1;
        wait_vok();
        #1;
        check("wd_restore_enable", int'(enable), 1);

        // Randomized requests, some reverting to the committed value
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(400, 30)) @(posedge clk);
            #1;
            if ($urandom_range(3) == 0) begin
                set_req(4'(m_com_s), 5'(m_com_o), m_com_e);
            end else begin
                set_req(4'($urandom_range(15)), 5'($urandom_range(31)), $urandom_range(3) != 0);
            end
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
